cache_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single cache controller between `NUM_REQ` request ports, e.g. several `obi_cache_interface` instances or a host port plus a maintenance engine. It accepts one complete operation/key/value request per port and grants one port at a time. It drives the controller's `operation`/`key`/`value` inputs until `ready_in`, then returns the result to the owning port as a one-cycle response pulse. A watchdog counter aborts operations the controller never completes.

---
 rtl/ctrl_types_pkg.sv | 19 +
 rtl/if_types_pkg.sv | 8 +
 rtl/cache_rr_pick.sv | 36 +++
 rtl/cache_req_arbiter.sv | 166 ++++++++++++++++
 tb/tb_cache_req_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_types_pkg.sv
// Cache controller operation codes and the request arbiter's state type.
package ctrl_types_pkg;

  import if_types_pkg::OP_WIDTH;

  typedef enum logic [OP_WIDTH-1:0] {
    NOOP = OP_WIDTH'(0),
    GET  = OP_WIDTH'(1),
    PUT  = OP_WIDTH'(2),
    DEL  = OP_WIDTH'(3)
  } operation_e;

  typedef enum logic [1:0] {
    ARB_ST_IDLE  = 2'd0,
    ARB_ST_ISSUE = 2'd1,
    ARB_ST_RESP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/if_types_pkg.sv
// Shared widths of the cache controller request interface.
package if_types_pkg;

  localparam int KEY_WIDTH   = 16;
  localparam int VALUE_WIDTH = 32;
  localparam int OP_WIDTH    = 2;

endpackage

// File: rtl/cache_rr_pick.sv
// Combinational round-robin picker: first eligible port at or after rr_ptr_i,
// wrapping modulo NUM_REQ.
module cache_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan offsets from farthest to nearest so the nearest eligible port is written last and wins.
  always_comb begin
    grant_o  = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(rr_ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = cand[IDX_W-1:0];
      if (elig_i[cand_idx]) begin
        idx_o = cand_idx;
        any_o = 1'b1;
      end
    end
    if (any_o) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/cache_req_arbiter.sv
// Shares one cache controller between NUM_REQ requesters: round-robin grant,
// issue to the controller until ready_in, one-cycle response to the owner,
// and a watchdog that aborts operations the controller never completes.
//
// Handshakes: a requester raises req_valid_i with a stable payload and holds
// it until it sees its req_grant_o bit for one cycle; the payload is taken on
// that edge. Towards the controller, operation_out is non-NOOP only in ISSUE
// and ready_in (with op_succ_in/value_in) is a completion strobe that is only
// looked at in ISSUE. Each grant yields exactly one rsp_valid_o pulse.
module cache_req_arbiter
  import if_types_pkg::*;
  import ctrl_types_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ*OP_WIDTH-1:0]     req_op_i,
  input  logic [NUM_REQ*KEY_WIDTH-1:0]    req_key_i,
  input  logic [NUM_REQ*VALUE_WIDTH-1:0]  req_value_i,
  output logic [NUM_REQ-1:0]              req_grant_o,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  output logic                            rsp_succ_o,
  output logic                            rsp_timeout_o,
  output logic [VALUE_WIDTH-1:0]          rsp_value_o,
  output logic [OP_WIDTH-1:0]             operation_out,
  output logic [KEY_WIDTH-1:0]            key_out,
  output logic [VALUE_WIDTH-1:0]          value_out,
  input  logic                            ready_in,
  input  logic                            op_succ_in,
  input  logic [VALUE_WIDTH-1:0]          value_in,
  output logic [1:0]                      dbg_state_o,
  output logic [$clog2(NUM_REQ)-1:0]      dbg_rr_ptr_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  arb_state_e             state_q, state_d;
  logic [OP_WIDTH-1:0]    op_q, op_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [VALUE_WIDTH-1:0] val_q, val_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   succ_q, succ_d;
  logic                   tmo_q, tmo_d;
  logic [VALUE_WIDTH-1:0] rval_q, rval_d;

  logic [NUM_REQ-1:0]     elig;
  logic [NUM_REQ-1:0]     pick_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic [IDX_W-1:0]       next_ptr;

  // A port competes only with a valid, non-NOOP request.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid_i[i] && (req_op_i[i*OP_WIDTH +: OP_WIDTH] != NOOP);
    end
  end

  cache_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .elig_i   (elig),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (pick_grant),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign next_ptr = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

  // State, latched request, watchdog and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_ST_IDLE;
      op_q     <= '0;
      key_q    <= '0;
      val_q    <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      wd_q     <= '0;
      succ_q   <= 1'b0;
      tmo_q    <= 1'b0;
      rval_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      key_q    <= key_d;
      val_q    <= val_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      wd_q     <= wd_d;
      succ_q   <= succ_d;
      tmo_q    <= tmo_d;
      rval_q   <= rval_d;
    end
  end

  // Next-state: grant in IDLE, wait for ready_in or watchdog in ISSUE, one RESP cycle.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    key_d    = key_q;
    val_d    = val_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    wd_d     = wd_q;
    succ_d   = succ_q;
    tmo_d    = tmo_q;
    rval_d   = rval_q;
    unique case (state_q)
      ARB_ST_IDLE: begin
        if (pick_any) begin
          op_d     = req_op_i[pick_idx*OP_WIDTH +: OP_WIDTH];
          key_d    = req_key_i[pick_idx*KEY_WIDTH +: KEY_WIDTH];
          val_d    = req_value_i[pick_idx*VALUE_WIDTH +: VALUE_WIDTH];
          owner_d  = pick_idx;
          rr_ptr_d = next_ptr;
          wd_d     = '0;
          state_d  = ARB_ST_ISSUE;
        end
      end
      ARB_ST_ISSUE: begin
        if (wd_q != WD_MAX) wd_d = wd_q + 1'b1;
        // Completion takes precedence over a watchdog expiry in the same cycle.
        if (ready_in) begin
          succ_d  = op_succ_in;
          rval_d  = value_in;
          tmo_d   = 1'b0;
          state_d = ARB_ST_RESP;
        end else if (wd_q >= WD_LAST) begin
          succ_d  = 1'b0;
          rval_d  = '0;
          tmo_d   = 1'b1;
          state_d = ARB_ST_RESP;
        end
      end
      ARB_ST_RESP: state_d = ARB_ST_IDLE;
      default:     state_d = ARB_ST_IDLE;
    endcase
  end

  // Outputs decode from state; the grant is also masked while reset is held.
  always_comb begin
    req_grant_o   = (state_q == ARB_ST_IDLE && rst_n) ? pick_grant : '0;
    operation_out = (state_q == ARB_ST_ISSUE) ? op_q : NOOP;
    key_out       = key_q;
    value_out     = val_q;
    rsp_valid_o   = (state_q == ARB_ST_RESP) ? (NUM_REQ'(1) << owner_q) : '0;
    rsp_succ_o    = (state_q == ARB_ST_RESP) && succ_q;
    rsp_timeout_o = (state_q == ARB_ST_RESP) && tmo_q;
    rsp_value_o   = (state_q == ARB_ST_RESP) ? rval_q : '0;
    dbg_state_o   = state_q;
    dbg_rr_ptr_o  = rr_ptr_q;
  end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Bench for cache_req_arbiter: directed scenarios plus randomized traffic,
// checked by a negedge monitor against a transaction-level model.
module tb_cache_req_arbiter;

  import if_types_pkg::*;
  import ctrl_types_pkg::*;

  localparam int N     = 2;
  localparam int T     = 4;
  localparam int IW    = $clog2(N);
  localparam int EXP_W = N + 2 + VALUE_WIDTH;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]             req_valid;
  logic [N*OP_WIDTH-1:0]    req_op;
  logic [N*KEY_WIDTH-1:0]   req_key;
  logic [N*VALUE_WIDTH-1:0] req_value;
  logic [N-1:0]             req_grant_o;
  logic [N-1:0]             rsp_valid_o;
  logic                     rsp_succ_o;
  logic                     rsp_timeout_o;
  logic [VALUE_WIDTH-1:0]   rsp_value_o;
  logic [OP_WIDTH-1:0]      operation_out;
  logic [KEY_WIDTH-1:0]     key_out;
  logic [VALUE_WIDTH-1:0]   value_out;
  logic                     ready_in;
  logic                     op_succ_in;
  logic [VALUE_WIDTH-1:0]   value_in;
  logic [1:0]               dbg_state_o;
  logic [IW-1:0]            dbg_rr_ptr_o;

  cache_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid),
    .req_op_i      (req_op),
    .req_key_i     (req_key),
    .req_value_i   (req_value),
    .req_grant_o   (req_grant_o),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_succ_o    (rsp_succ_o),
    .rsp_timeout_o (rsp_timeout_o),
    .rsp_value_o   (rsp_value_o),
    .operation_out (operation_out),
    .key_out       (key_out),
    .value_out     (value_out),
    .ready_in      (ready_in),
    .op_succ_in    (op_succ_in),
    .value_in      (value_in),
    .dbg_state_o   (dbg_state_o),
    .dbg_rr_ptr_o  (dbg_rr_ptr_o)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [EXP_W-1:0] exp_q[$];
  int grant_log[$];

  // Reference model: phase 0 = free, 1 = operation outstanding, 2 = response due.
  int                     m_phase = 0;
  int                     m_ptr   = 0;
  int                     m_age   = 0;
  int                     m_port  = 0;
  logic [OP_WIDTH-1:0]    m_op    = '0;
  logic [KEY_WIDTH-1:0]   m_key   = '0;
  logic [VALUE_WIDTH-1:0] m_val   = '0;
  logic [N-1:0]           m_grant_vec = '0;

  logic [N-1:0] pend = '0;
  int noop_left[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / reference model ----------------
  always @(negedge clk) begin
    int w;
    int p;
    logic [N-1:0] oh;
    logic [EXP_W-1:0] exp_v;
    logic [EXP_W-1:0] act_v;
    if (!rst_n) begin
      check("reset_ctrl", 64'({req_grant_o, rsp_valid_o, rsp_succ_o, rsp_timeout_o,
                               operation_out, dbg_state_o, dbg_rr_ptr_o}), 64'd0);
      check("reset_key", 64'(key_out), 64'd0);
      check("reset_values", 64'({rsp_value_o, value_out}), 64'd0);
      m_phase = 0;
      m_ptr = 0;
      m_grant_vec = '0;
      exp_q.delete();
    end else begin
      m_grant_vec = '0;
      act_v = {rsp_valid_o, rsp_succ_o, rsp_timeout_o, rsp_value_o};
      if (rsp_valid_o != '0) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(act_v), 64'd0);
        end else begin
          exp_v = exp_q.pop_front();
          check("rsp_payload", 64'(act_v), 64'(exp_v));
        end
      end
      case (m_phase)
        0: begin
          w = -1;
          for (int k = 0; k < N; k++) begin
            p = (m_ptr + k) % N;
            if (w < 0 && req_valid[p] && req_op[p*OP_WIDTH +: OP_WIDTH] != NOOP) w = p;
          end
          check("idle_op_noop", 64'(operation_out), 64'(NOOP));
          if (w >= 0) begin
            check("grant", 64'(req_grant_o), 64'd1 << w);
            m_grant_vec[w] = 1'b1;
            m_port  = w;
            m_op    = req_op[w*OP_WIDTH +: OP_WIDTH];
            m_key   = req_key[w*KEY_WIDTH +: KEY_WIDTH];
            m_val   = req_value[w*VALUE_WIDTH +: VALUE_WIDTH];
            m_ptr   = (w + 1) % N;
            m_age   = 0;
            m_phase = 1;
            grant_log.push_back(w);
          end else begin
            check("grant_none", 64'(req_grant_o), 64'd0);
          end
        end
        1: begin
          m_age++;
          oh = N'(1) << m_port;
          check("busy_no_grant", 64'(req_grant_o), 64'd0);
          check("issue_op", 64'(operation_out), 64'(m_op));
          check("issue_key_value", 64'({key_out, value_out}), 64'({m_key, m_val}));
          if (ready_in) begin
            exp_q.push_back({oh, op_succ_in, 1'b0, value_in});
            m_phase = 2;
          end else if (m_age == T) begin
            exp_q.push_back({oh, 1'b0, 1'b1, VALUE_WIDTH'(0)});
            m_phase = 2;
          end
        end
        default: begin
          check("rsp_present", 64'(rsp_valid_o != '0), 64'd1);
          check("resp_op_noop", 64'(operation_out), 64'(NOOP));
          check("resp_no_grant", 64'(req_grant_o), 64'd0);
          m_phase = 0;
        end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (m_grant_vec[i]) begin
        req_valid[i] = 1'b0;
        pend[i] = 1'b0;
      end
    end
  endtask

  task automatic set_req(input int i, input logic [OP_WIDTH-1:0] op,
                         input logic [KEY_WIDTH-1:0] k, input logic [VALUE_WIDTH-1:0] v);
    req_valid[i] = 1'b1;
    req_op[i*OP_WIDTH +: OP_WIDTH] = op;
    req_key[i*KEY_WIDTH +: KEY_WIDTH] = k;
    req_value[i*VALUE_WIDTH +: VALUE_WIDTH] = v;
    pend[i] = 1'b1;
  endtask

  task automatic drain();
    ready_in = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (pend == '0 && m_phase == 0) break;
      tick();
    end
    check("drain_done", 64'(pend == '0 && m_phase == 0), 64'd1);
    ready_in = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    logic [OP_WIDTH-1:0] opv;
    req_valid = '0;
    req_op = '0;
    req_key = '0;
    req_value = '0;
    ready_in = 1'b0;
    op_succ_in = 1'b0;
    value_in = '0;
    for (int i = 0; i < N; i++) noop_left[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ptr", 64'(dbg_rr_ptr_o), 64'd0);
    rst_n = 1'b1;

    // Round-robin fairness from reset: both ports always requesting.
    ready_in = 1'b1;
    op_succ_in = 1'b1;
    set_req(0, GET, 16'h0100, 32'h1111_0000);
    set_req(1, PUT, 16'h0200, 32'h2222_0000);
    for (int c = 0; c < 14; c++) begin
      tick();
      value_in = $urandom();
      for (int i = 0; i < N; i++)
        if (!pend[i]) set_req(i, OP_WIDTH'($urandom_range(1, 3)), KEY_WIDTH'($urandom()), $urandom());
    end
    drain();
    check("rr_count", 64'(grant_log.size() >= 4), 64'd1);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      check("rr_order", 64'(grant_log[k]), 64'(k % 2));
    grant_log.delete();

    // Single request, then ready_in held high through RESP and IDLE.
    ready_in = 1'b0;
    set_req(0, PUT, 16'h0012, 32'hDEAD_BEEF);
    tick();
    check("single_op", 64'(operation_out), 64'(PUT));
    check("single_key", 64'(key_out), 64'h12);
    ready_in = 1'b1;
    op_succ_in = 1'b1;
    value_in = 32'h0BAD_F00D;
    tick();
    check("single_rsp_valid", 64'(rsp_valid_o), 64'b01);
    check("single_rsp_succ", 64'(rsp_succ_o), 64'd1);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("stray_ready_state", 64'(dbg_state_o), 64'(ARB_ST_IDLE));
      check("stray_ready_rsp", 64'(rsp_valid_o), 64'd0);
    end
    ready_in = 1'b0;

    // NOOP request is never granted.
    req_valid[1] = 1'b1;
    req_op[OP_WIDTH +: OP_WIDTH] = NOOP;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("noop_state", 64'(dbg_state_o), 64'(ARB_ST_IDLE));
      check("noop_grant", 64'(req_grant_o), 64'd0);
      check("noop_op", 64'(operation_out), 64'(NOOP));
    end
    req_valid[1] = 1'b0;

    // Watchdog expiry with ready_in held low.
    set_req(0, GET, 16'h0033, 32'h0);
    tick();
    cyc = 1;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid_o != '0) break;
      tick();
      cyc++;
    end
    check("wd_latency", 64'(cyc), 64'(T + 1));
    check("wd_rsp", 64'({rsp_succ_o, rsp_timeout_o, rsp_value_o}), {31'd0, 1'b0, 1'b1, 32'd0});
    tick();

    // ready_in arriving in the expiry cycle wins.
    set_req(0, DEL, 16'h0044, 32'h4444_4444);
    tick();
    repeat (T - 1) tick();
    ready_in = 1'b1;
    op_succ_in = 1'b1;
    value_in = 32'hC0DE_0001;
    tick();
    ready_in = 1'b0;
    check("wd_edge_rsp", 64'({rsp_valid_o, rsp_succ_o, rsp_timeout_o, rsp_value_o}),
          64'({2'b01, 1'b1, 1'b0, 32'hC0DE_0001}));
    tick();

    // Reset during ISSUE drops the operation and the pointer.
    set_req(0, PUT, 16'h0055, 32'h5555_5555);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_async_ctrl", 64'({req_grant_o, rsp_valid_o, rsp_succ_o, rsp_timeout_o,
                                 operation_out, dbg_state_o}), 64'd0);
    check("rst_async_ptr", 64'(dbg_rr_ptr_o), 64'd0);
    check("rst_async_key", 64'(key_out), 64'd0);
    repeat (2) tick();
    grant_log.delete();
    set_req(0, GET, 16'h0066, 32'h6666_6666);
    set_req(1, GET, 16'h0077, 32'h7777_7777);
    ready_in = 1'b1;
    rst_n = 1'b1;
    tick();
    check("rst_first_winner", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd0);
    drain();

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      tick();
      ready_in = ($urandom_range(0, 9) < 4);
      op_succ_in = 1'($urandom_range(0, 1));
      value_in = $urandom();
      for (int i = 0; i < N; i++) begin
        if (noop_left[i] > 0) begin
          noop_left[i]--;
          if (noop_left[i] == 0) req_valid[i] = 1'b0;
        end else if (!pend[i] && $urandom_range(0, 2) == 0) begin
          opv = OP_WIDTH'($urandom_range(0, 3));
          if (opv == NOOP) begin
            req_valid[i] = 1'b1;
            req_op[i*OP_WIDTH +: OP_WIDTH] = NOOP;
            noop_left[i] = $urandom_range(1, 3);
          end else begin
            set_req(i, opv, KEY_WIDTH'($urandom()), $urandom());
          end
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (noop_left[i] > 0) begin
        noop_left[i] = 0;
        req_valid[i] = 1'b0;
      end
    end
    drain();
    repeat (3) tick();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got no end, expected end");
    $fatal(1);
  end

endmodule
